pr_recover_ctrl: RTL and testbench
==================================

PR_RECOVER_CTRL -- requirements
Module: pr_recover_ctrl

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 32, the number of ROB entries (power of two).
REQ-002 SHALL have parameter PR_W, default 6, the physical-register index width.
REQ-003 SHALL have parameter AR_W, default 5, the architectural-register index width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port mispredict  in  1  one-cycle pulse from EX: a branch was mispredicted.
REQ-007 SHALL have port branch_rob_idx  in  log2(ROB_DEPTH)  ROB index of the mispredicted branch.
REQ-008 SHALL have port rob_tail  in  log2(ROB_DEPTH)  current ROB tail (next free slot).
REQ-009 SHALL have port rob_rd_idx  out  log2(ROB_DEPTH)  ROB entry read this cycle.
REQ-010 SHALL have port rob_rd_regdest  in  1  entry at rob_rd_idx writes a register (same-cycle combinational read).
REQ-011 SHALL have port rob_rd_pr_new  in  PR_W  PR allocated by that entry.
REQ-012 SHALL have port rob_rd_pr_old  in  PR_W  PR previously mapped to that entry's destination.
REQ-013 SHALL have port rob_rd_ar  in  AR_W  destination architectural register of that entry.
REQ-014 SHALL have port recover  out  1  push pr_flush back into the free list this cycle.
REQ-015 SHALL have port pr_flush  out  PR_W  PR returned to the free list.
REQ-016 SHALL have port stall_recover  out  1  freezes rename allocation, retire and EX while recovering.
REQ-017 SHALL have port map_wr_en / map_wr_ar / map_wr_pr  out  1/AR_W/PR_W  rename-map rollback write.
REQ-018 SHALL have port rob_tail_set / rob_tail_new  out  1/log2(ROB_DEPTH)  forces ROB tail on completion.
REQ-019 SHALL have port done  out  1  one-cycle pulse at end of recovery.

Function
REQ-020 SHALL implement FSM IDLE -> WALK -> DONE -> IDLE; state is registered.
REQ-021 SHALL, in IDLE on mispredict, latch stop = (branch_rob_idx+1) mod ROB_DEPTH and ptr = (rob_tail-1) mod ROB_DEPTH; next state WALK if rob_tail != stop, else DONE.
REQ-022 SHALL, in WALK, drive rob_rd_idx = ptr; when rob_rd_regdest=1, assert recover, pr_flush=rob_rd_pr_new, map_wr_en, map_wr_ar=rob_rd_ar, map_wr_pr=rob_rd_pr_old, all combinationally in the same cycle.
REQ-023 SHALL, in WALK, go to DONE when ptr == stop, else decrement ptr modulo ROB_DEPTH (wrap 0 -> ROB_DEPTH-1).
REQ-024 SHALL walk youngest to oldest so the last map write per AR restores the oldest squashed pr_old.
REQ-025 SHALL, in DONE, assert done, rob_tail_set and rob_tail_new=stop for exactly one cycle, then return to IDLE.
REQ-026 SHALL assert stall_recover = (state != IDLE); it rises the cycle after mispredict and falls the cycle after DONE.
REQ-027 SHALL take exactly N+1 cycles from WALK entry to IDLE for N = (rob_tail - stop) mod ROB_DEPTH squashed entries; N=0 costs one DONE cycle.
REQ-028 SHALL ignore mispredict outside IDLE (EX is frozen by stall_recover, so none arrives legally).
REQ-029 SHALL hold recover, map_wr_en, rob_tail_set, done at 0 outside the states named above; pr_flush/map data are don't-care when their enables are 0.
REQ-030 SHALL handle a full ROB (N = ROB_DEPTH-1) with no special case.

Reset
REQ-031 SHALL, when rst=1 at a clock edge, enter IDLE and clear ptr and stop, including mid-WALK (the partial walk is abandoned).
REQ-032 SHALL drive every output 0 while in IDLE after reset.

Structure
REQ-033 SHALL take ROB_DEPTH, PR_W, AR_W defaults and the FSM state encoding from the shared OoO pipeline package.
REQ-034 SHALL be a single module; no sub-module is warranted.

Verification
REQ-035 Branch idx 4, rob_tail 8, entries 5-7 all regdest (pr_new 40,41,42) -> recover on 3 consecutive cycles with pr_flush 42,41,40; then done, rob_tail_new=5.
REQ-036 Branch idx 9, rob_tail 10 -> no recover; DONE the cycle after mispredict; stall_recover high exactly 1 cycle.
REQ-037 Branch idx 30, rob_tail 2 -> rob_rd_idx sequence 1,0,31; rob_tail_new=31.
REQ-038 Entries 5 and 7 both write AR3 (pr_old 12 and 40) -> map writes AR3<-40 then AR3<-12; entry 6 regdest=0 gives no recover that cycle.
REQ-039 rst asserted on second WALK cycle -> next cycle IDLE, all outputs 0; a new mispredict then runs normally.
REQ-040 Second mispredict pulse during WALK -> ignored; walk completes unchanged.

Source files
------------

// File: rtl/pr_recover_ctrl_pkg.sv
// ============================================================================
// pr_recover_ctrl_pkg : shared OoO pipeline defaults and recovery FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pr_recover_ctrl_pkg;

  localparam int ROB_DEPTH_DEF = 32;
  localparam int PR_W_DEF      = 6;
  localparam int AR_W_DEF      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } rcv_state_t;

endpackage

`default_nettype wire

// File: rtl/pr_recover_ctrl.sv
// ============================================================================
// pr_recover_ctrl : mispredict recovery, walks squashed ROB entries youngest
// to oldest, freeing PRs and rolling back the rename map. Rev 1.0
// ============================================================================
`default_nettype none

module pr_recover_ctrl
  import pr_recover_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF,
  parameter int PR_W      = PR_W_DEF,
  parameter int AR_W      = AR_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mispredict,
  input  logic [$clog2(ROB_DEPTH)-1:0] branch_rob_idx,
  input  logic [$clog2(ROB_DEPTH)-1:0] rob_tail,
  output logic [$clog2(ROB_DEPTH)-1:0] rob_rd_idx,
  input  logic                         rob_rd_regdest,
  input  logic [PR_W-1:0]              rob_rd_pr_new,
  input  logic [PR_W-1:0]              rob_rd_pr_old,
  input  logic [AR_W-1:0]              rob_rd_ar,
  output logic                         recover,
  output logic [PR_W-1:0]              pr_flush,
  output logic                         stall_recover,
  output logic                         map_wr_en,
  output logic [AR_W-1:0]              map_wr_ar,
  output logic [PR_W-1:0]              map_wr_pr,
  output logic                         rob_tail_set,
  output logic [$clog2(ROB_DEPTH)-1:0] rob_tail_new,
  output logic                         done
);

  localparam int IW = $clog2(ROB_DEPTH);

  rcv_state_t      r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_stop;

  logic [IW-1:0]   w_stop_start;
  logic [IW-1:0]   w_ptr_start;
  logic            w_walk;
  logic            w_hit;
  logic            w_done;

  // Power-of-two depth: index arithmetic wraps naturally modulo ROB_DEPTH.
  assign w_stop_start = branch_rob_idx + 1'b1;
  assign w_ptr_start  = rob_tail - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_stop  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mispredict) begin
            r_stop  <= w_stop_start;
            r_ptr   <= w_ptr_start;
            r_state <= (rob_tail != w_stop_start) ? ST_WALK : ST_DONE;
          end
        end
        ST_WALK: begin
          if (r_ptr == r_stop) begin
            r_state <= ST_DONE;
          end else begin
            r_ptr <= r_ptr - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_walk = (r_state == ST_WALK);
  assign w_hit  = w_walk & rob_rd_regdest;
  assign w_done = (r_state == ST_DONE);

  // Data outputs are zeroed when not enabled so IDLE drives all-zero.
  assign rob_rd_idx    = w_walk ? r_ptr : '0;
  assign recover       = w_hit;
  assign pr_flush      = w_hit ? rob_rd_pr_new : '0;
  assign map_wr_en     = w_hit;
  assign map_wr_ar     = w_hit ? rob_rd_ar : '0;
  assign map_wr_pr     = w_hit ? rob_rd_pr_old : '0;
  assign stall_recover = (r_state != ST_IDLE);
  assign done          = w_done;
  assign rob_tail_set  = w_done;
  assign rob_tail_new  = w_done ? r_stop : '0;

endmodule

`default_nettype wire

// File: tb/tb_pr_recover_ctrl.sv
// ============================================================================
// tb_pr_recover_ctrl : directed and random recoveries against a ROB / rename
// map reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_pr_recover_ctrl;

  localparam int D  = 32;
  localparam int IW = 5;
  localparam int PW = 6;
  localparam int AW = 5;
  localparam int NA = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mispredict;
  logic [IW-1:0] branch_rob_idx;
  logic [IW-1:0] rob_tail;
  logic [IW-1:0] rob_rd_idx;
  logic          rob_rd_regdest;
  logic [PW-1:0] rob_rd_pr_new;
  logic [PW-1:0] rob_rd_pr_old;
  logic [AW-1:0] rob_rd_ar;
  logic          recover;
  logic [PW-1:0] pr_flush;
  logic          stall_recover;
  logic          map_wr_en;
  logic [AW-1:0] map_wr_ar;
  logic [PW-1:0] map_wr_pr;
  logic          rob_tail_set;
  logic [IW-1:0] rob_tail_new;
  logic          done;

  // ROB contents model, read combinationally at the index the DUT requests
  logic          m_rd  [D];
  logic [PW-1:0] m_new [D];
  logic [PW-1:0] m_old [D];
  logic [AW-1:0] m_ar  [D];

  logic [PW-1:0] map_dut [NA];
  logic [PW-1:0] map_exp [NA];

  int n_cmp = 0;
  int n_bad = 0;

  assign rob_rd_regdest = m_rd[rob_rd_idx];
  assign rob_rd_pr_new  = m_new[rob_rd_idx];
  assign rob_rd_pr_old  = m_old[rob_rd_idx];
  assign rob_rd_ar      = m_ar[rob_rd_idx];

  always #5 clk = ~clk;

  pr_recover_ctrl #(.ROB_DEPTH(D), .PR_W(PW), .AR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .mispredict     (mispredict),
    .branch_rob_idx (branch_rob_idx),
    .rob_tail       (rob_tail),
    .rob_rd_idx     (rob_rd_idx),
    .rob_rd_regdest (rob_rd_regdest),
    .rob_rd_pr_new  (rob_rd_pr_new),
    .rob_rd_pr_old  (rob_rd_pr_old),
    .rob_rd_ar      (rob_rd_ar),
    .recover        (recover),
    .pr_flush       (pr_flush),
    .stall_recover  (stall_recover),
    .map_wr_en      (map_wr_en),
    .map_wr_ar      (map_wr_ar),
    .map_wr_pr      (map_wr_pr),
    .rob_tail_set   (rob_tail_set),
    .rob_tail_new   (rob_tail_new),
    .done           (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    logic [31:0] w_all;
    w_all = 32'({stall_recover, recover, map_wr_en, done, rob_tail_set}) |
            32'(rob_tail_new) | 32'(rob_rd_idx) | 32'(pr_flush) |
            32'(map_wr_ar) | 32'(map_wr_pr);
    check_eq(tag, w_all, 32'd0);
  endtask

  task automatic rand_rob();
    for (int i = 0; i < D; i++) begin
      m_rd[i]  = 1'($urandom_range(0, 1));
      m_new[i] = PW'($urandom);
      m_old[i] = PW'($urandom);
      m_ar[i]  = AW'($urandom);
    end
  endtask

  // One recovery: cycle 0 pulses mispredict, then N walk cycles, DONE, IDLE.
  // rst_cyc > 0 asserts reset after that walk cycle; extra_mp pulses a
  // second mispredict on walk cycle 2.
  task automatic run_rec(input int bidx, input int tail, input int rst_cyc, input bit extra_mp);
    int stop, n, idx;
    bit claimed [NA];
    stop = (bidx + 1) % D;
    n    = (tail - stop + D) % D;

    // Rollback target: each AR ends at the pr_old of its oldest squashed writer.
    for (int a = 0; a < NA; a++) begin
      map_dut[a] = PW'($urandom);
      map_exp[a] = map_dut[a];
      claimed[a] = 1'b0;
    end
    for (int j = 0; j < n; j++) begin
      idx = (stop + j) % D;
      if (m_rd[idx] && !claimed[m_ar[idx]]) begin
        map_exp[m_ar[idx]] = m_old[idx];
        claimed[m_ar[idx]] = 1'b1;
      end
    end

    @(posedge clk); #1;
    mispredict     = 1'b1;
    branch_rob_idx = IW'(bidx);
    rob_tail       = IW'(tail);
    #4 check_idle("pre_idle");

    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      mispredict     = extra_mp && (k == 2);
      branch_rob_idx = IW'($urandom);
      rob_tail       = IW'($urandom);
      #4;
      idx = (tail - k + D) % D;
      check_eq("walk_stall", 32'(stall_recover), 32'd1);
      check_eq("walk_idx", 32'(rob_rd_idx), 32'(idx));
      check_eq("walk_recover", 32'(recover), 32'(m_rd[idx]));
      check_eq("walk_done", 32'(done), 32'd0);
      if (m_rd[idx]) begin
        check_eq("pr_flush", 32'(pr_flush), 32'(m_new[idx]));
        check_eq("map_wr", 32'({map_wr_en, map_wr_ar, map_wr_pr}),
                 32'({1'b1, m_ar[idx], m_old[idx]}));
      end
      if (map_wr_en) map_dut[map_wr_ar] = map_wr_pr;
      if (k == rst_cyc) begin
        rst = 1'b1;
        mispredict = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #4 check_idle("rst_idle");
        return;
      end
    end

    @(posedge clk); #1;
    mispredict = 1'b0;
    #4;
    check_eq("done_pulse", 32'({done, rob_tail_set, stall_recover, recover}), 32'b1110);
    check_eq("tail_new", 32'(rob_tail_new), 32'(stop));

    @(posedge clk); #5;
    check_idle("post_idle");
    for (int a = 0; a < NA; a++) begin
      if (claimed[a]) check_eq($sformatf("map_ar%0d", a), 32'(map_dut[a]), 32'(map_exp[a]));
    end
  endtask

  initial begin
    rst = 1'b1;
    mispredict = 1'b0;
    branch_rob_idx = '0;
    rob_tail = '0;
    rand_rob();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #4 check_idle("reset_state");

    // Three consecutive frees, youngest first
    rand_rob();
    for (int i = 5; i <= 7; i++) begin
      m_rd[i]  = 1'b1;
      m_new[i] = PW'(35 + i);
    end
    run_rec(4, 8, 0, 1'b0);

    // Nothing squashed: straight to DONE
    run_rec(9, 10, 0, 1'b0);

    // Pointer wraps 0 -> 31
    rand_rob();
    run_rec(30, 2, 0, 1'b0);

    // Same AR written twice, hole in the middle
    rand_rob();
    m_rd[5] = 1'b1; m_ar[5] = AW'(3); m_old[5] = PW'(12);
    m_rd[6] = 1'b0;
    m_rd[7] = 1'b1; m_ar[7] = AW'(3); m_old[7] = PW'(40);
    run_rec(4, 8, 0, 1'b0);

    // Reset on second walk cycle, then a normal recovery
    rand_rob();
    run_rec(4, 8, 2, 1'b0);
    run_rec(4, 8, 0, 1'b0);

    // Stray mispredict mid-walk is ignored
    rand_rob();
    run_rec(10, 20, 0, 1'b1);

    // Full ROB
    rand_rob();
    run_rec(7, 7, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rand_rob();
      run_rec(int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)), 0,
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
